// File: rtl/serial_word_framer.sv
// serial_word_framer: hunts for a sync pattern, then frames the following WIDTH bits MSB-first into a valid/ready word register.
module serial_word_framer #(
    parameter int WIDTH = 8,
    parameter int SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'b1010_0101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             locked,
    output logic             overflow,
    output logic [7:0]       frame_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t            state, state_d;
    logic [SYNC_W-1:0] sync_sr, sync_d;
    logic [WIDTH-1:0]  data_sr, data_d, word_d;
    logic [CW-1:0]     bit_cnt, cnt_d;
    logic              valid_d, ovf_d, done;
    logic [7:0]        fcnt_d;

    assign locked = (state == COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            sync_sr    <= '0;
            data_sr    <= '0;
            bit_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_d;
            sync_sr    <= sync_d;
            data_sr    <= data_d;
            bit_cnt    <= cnt_d;
            word       <= word_d;
            word_valid <= valid_d;
            overflow   <= ovf_d;
            frame_cnt  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        sync_d  = sync_sr;
        data_d  = data_sr;
        cnt_d   = bit_cnt;
        word_d  = word;
        valid_d = word_valid;
        ovf_d   = overflow;
        fcnt_d  = frame_cnt;
        done    = 1'b0;
        if (din_en) begin
            if (state == HUNT) begin
                sync_d = {sync_sr[SYNC_W-2:0], din};
                if (sync_d == SYNC_PAT) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end else begin
                data_d = {data_sr[WIDTH-2:0], din};
                cnt_d  = bit_cnt + CW'(1);
                if (bit_cnt == LAST) begin
                    done    = 1'b1;
                    state_d = HUNT;
                    sync_d  = '0;
                    cnt_d   = '0;
                end
            end
        end
        if (word_valid && word_ready)
            valid_d = 1'b0;
        // a completed word only lands if the slot is empty or being emptied this edge
        if (done) begin
            if (!word_valid || word_ready) begin
                word_d  = data_d;
                valid_d = 1'b1;
                fcnt_d  = frame_cnt + 8'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_word_framer.sv
// tb_serial_word_framer: randomized and directed stimulus checked every cycle against a behavioural framer model.
module tb_serial_word_framer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word;
    logic       word_valid, locked, overflow;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // model state: bit history while hunting, bit count and accumulator while collecting
    int m_hist, m_n, m_acc, m_word, m_fcnt;
    bit m_locked, m_valid, m_ovf;

    serial_word_framer dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en),
        .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .locked(locked), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist <= 0; m_n <= 0; m_acc <= 0; m_word <= 0; m_fcnt <= 0;
            m_locked <= 0; m_valid <= 0; m_ovf <= 0;
        end else begin
            automatic int h = m_hist, n = m_n, acc = m_acc, w = m_word, f = m_fcnt;
            automatic bit lk = m_locked, v = m_valid, o = m_ovf;
            automatic bit consumed = m_valid && word_ready;
            if (consumed) v = 0;
            if (din_en) begin
                if (!lk) begin
                    h = (h * 2 + din) % 256;
                    if (h == 'hA5) begin lk = 1; n = 0; acc = 0; end
                end else begin
                    acc = (acc * 2 + din) % 256;
                    n = n + 1;
                    if (n == 8) begin
                        lk = 0; h = 0; n = 0;
                        if (!m_valid || consumed) begin w = acc; v = 1; f = (f + 1) % 256; end
                        else o = 1;
                    end
                end
            end
            m_hist <= h; m_n <= n; m_acc <= acc; m_word <= w; m_fcnt <= f;
            m_locked <= lk; m_valid <= v; m_ovf <= o;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("word", word, m_word);
            chk("word_valid", word_valid, m_valid);
            chk("locked", locked, m_locked);
            chk("overflow", overflow, m_ovf);
            chk("frame_cnt", frame_cnt, m_fcnt);
        end
    end

    task automatic tick(input logic d, input logic e, input logic r);
        @(negedge clk);
        din = d; din_en = e; word_ready = r;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input logic r, input logic r_last);
        for (int i = 7; i >= 0; i--) begin
            if (gaps)
                for (int g = 0; g < 3; g++)
                    if ($urandom_range(0, 2) == 0) tick(1'($urandom), 1'b0, r);
            tick(b[i], 1'b1, i == 0 ? r_last : r);
        end
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_word", word, 0);
        chk("reset_valid", word_valid, 0);
        chk("reset_fcnt", frame_cnt, 0);
        rst = 1'b0;

        // basic frame with ready high
        send_byte(8'hA5, 0, 1, 1);
        after_edge;
        chk("lock_after_sync", locked, 1);
        send_byte(8'h3C, 0, 1, 1);
        after_edge;
        chk("basic_word", word, 8'h3C);
        chk("basic_valid", word_valid, 1);
        chk("basic_fcnt", frame_cnt, 1);
        chk("basic_unlocked", locked, 0);
        chk("model_word", m_word, 8'h3C);
        tick(0, 0, 1);
        after_edge;
        chk("basic_valid_drop", word_valid, 0);

        // near miss: no window of A4 A7 25 equals the sync pattern
        send_byte(8'hA4, 0, 1, 1);
        send_byte(8'hA7, 0, 1, 1);
        send_byte(8'h25, 0, 1, 1);
        after_edge;
        chk("near_miss_locked", locked, 0);
        chk("near_miss_valid", word_valid, 0);
        chk("near_miss_fcnt", frame_cnt, 1);

        // disabled cycles between bits must not shift
        send_byte(8'hA5, 1, 1, 1);
        send_byte(8'h3C, 1, 1, 1);
        after_edge;
        chk("gap_word", word, 8'h3C);
        chk("gap_fcnt", frame_cnt, 2);

        // asynchronous reset in the middle of a frame
        send_byte(8'hA5, 0, 1, 1);
        tick(1, 1, 1); tick(0, 1, 1); tick(1, 1, 1);
        after_edge;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_fcnt", frame_cnt, 0);
        chk("async_rst_valid", word_valid, 0);
        chk("async_rst_word", word, 0);
        @(negedge clk);
        din_en = 1'b0; word_ready = 1'b0;
        rst = 1'b0;
        after_edge;
        chk("hunt_after_rst", locked, 0);

        // backpressure: second frame dropped
        send_byte(8'hA5, 0, 0, 0);
        send_byte(8'h3C, 0, 0, 0);
        send_byte(8'hA5, 0, 0, 0);
        send_byte(8'hC3, 0, 0, 0);
        after_edge;
        chk("bp_word", word, 8'h3C);
        chk("bp_overflow", overflow, 1);
        chk("bp_fcnt", frame_cnt, 1);
        chk("bp_valid", word_valid, 1);
        tick(0, 0, 1);
        after_edge;
        chk("bp_valid_drop", word_valid, 0);
        chk("bp_word_kept", word, 8'h3C);

        // same-edge consume and reload
        send_byte(8'hA5, 0, 0, 0);
        send_byte(8'h11, 0, 0, 0);
        send_byte(8'hA5, 0, 0, 0);
        send_byte(8'h22, 0, 0, 1);
        after_edge;
        chk("same_edge_word", word, 8'h22);
        chk("same_edge_valid", word_valid, 1);
        chk("same_edge_fcnt", frame_cnt, 3);

        // wrap: 253 more loads brings the count to 256
        for (int k = 0; k < 253; k++) begin
            send_byte(8'hA5, k % 4 == 0, 1, 1);
            send_byte(8'($urandom), 0, 1, 1);
        end
        after_edge;
        chk("wrap_fcnt", frame_cnt, 0);

        // random soak against the model
        for (int k = 0; k < 150; k++) begin
            automatic logic r = 1'($urandom);
            if ($urandom_range(0, 1) == 1) send_byte(8'hA5, 1, r, 1'($urandom));
            send_byte(8'($urandom), 1, r, 1'($urandom));
            for (int j = 0; j < 8; j++) tick(1'($urandom), 1'($urandom), 1'($urandom));
        end
        tick(0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
